// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-way round-robin arbiter with a bounded hold time.
//
// A requester keeps the grant while it holds its req bit. When it releases,
// or when it has held the grant for MAX_HOLD cycles while someone else waits,
// the grant rotates: the priority pointer moves to one past the old holder and
// the next pending requester is granted on the same edge (no idle gap).
//
// Parameters
//   MAX_HOLD  : max consecutive grant cycles while another requester waits (1..255)
// Ports
//   clk       : in  1  rising-edge clock
//   rst_n     : in  1  asynchronous active-low reset
//   req       : in  8  request vector, bit k = requester k
//   gnt       : out 8  registered one-hot grant, zero when idle
//   gnt_idx   : out 3  index of current holder, zero when idle
//   gnt_valid : out 1  high exactly when gnt is non-zero
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_TO  = 8'(MAX_HOLD - 1);

    logic [0:0] r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_idx;
    logic [7:0] r_gnt;
    logic [7:0] r_hold;

    logic [2:0] w_base;
    logic [7:0] w_mask;
    logic [2:0] w_cand;
    logic [2:0] w_sel;
    logic       w_found;
    logic       w_rotate;

    // One search serves both cases: in IDLE it starts at ptr, in GRANT it
    // starts one past the holder (the pointer value after rotation). The
    // holder is masked out; r_gnt is zero in IDLE so the mask is just req.
    always_comb begin
        w_base  = (r_state == S_IDLE) ? r_ptr : r_idx + 3'd1;
        w_mask  = req & ~r_gnt;
        w_cand  = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_cand = w_base + 3'(i);
            if (!w_found && w_mask[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Rotate on release, or on timeout only when another requester is waiting;
    // with nobody waiting a timed-out holder keeps the grant.
    always_comb begin
        w_rotate = !req[r_idx] || ((r_hold >= HOLD_TO) && w_found);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_GRANT;
                        r_idx   <= w_sel;
                        r_gnt   <= 8'b1 << w_sel;
                        r_hold  <= '0;
                    end
                end
                default: begin
                    if (w_rotate) begin
                        r_ptr <= r_idx + 3'd1;
                        if (w_found) begin
                            r_idx  <= w_sel;
                            r_gnt  <= 8'b1 << w_sel;
                            r_hold <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                            r_gnt   <= '0;
                            r_hold  <= '0;
                        end
                    end else if (r_hold < HOLD_LIM) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = (r_state == S_GRANT);

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] ei, input logic ev);
        logic [7:0] eg;
        eg = ev ? (8'b1 << ei) : 8'h00;
        n_cmp++;
        assert (gnt === eg && gnt_idx === ei && gnt_valid === ev)
        else begin
            n_err++;
            $error("FAIL %s: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                   tag, gnt, gnt_idx, gnt_valid, eg, ei, ev);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        #2;
        chk("rst_pulse", 3'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        #7;
        chk("reset", 3'd0, 1'b0);
        rst_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle", 3'd0, 1'b0);
        end

        // Basic grant and back-to-back handoff
        req = 8'b0010_0100;
        step();
        chk("first_gnt2", 3'd2, 1'b1);
        req = 8'b0010_0000;
        step();
        chk("handoff5", 3'd5, 1'b1);
        req = 8'b0000_0000;
        step();
        chk("release_idle", 3'd0, 1'b0);

        // Full rotation with pointer wrap 7 -> 0
        step();
        pulse_reset();
        req = 8'hFF;
        step();
        chk("rot_start0", 3'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] r;
            r   = 8'b1 << k;
            req = ~r;
            step();
            chk($sformatf("rot_%0d", (k + 1) % 8), 3'((k + 1) % 8), 1'b1);
        end
        req = 8'h00;
        step();
        chk("rot_idle", 3'd0, 1'b0);

        // Timeout: ptr=1, req[3] held, req[6] joins one cycle later
        req = 8'b0000_1000;
        step();
        chk("to_gnt3_c1", 3'd3, 1'b1);
        req = 8'b0100_1000;
        step();
        chk("to_gnt3_c2", 3'd3, 1'b1);
        step();
        chk("to_gnt3_c3", 3'd3, 1'b1);
        step();
        chk("to_gnt3_c4", 3'd3, 1'b1);
        step();
        chk("to_gnt6", 3'd6, 1'b1);
        req = 8'h00;
        step();
        chk("to_idle", 3'd0, 1'b0);

        // Saturated hold with no competitor: ptr=7, search 7,0,1
        req = 8'b0000_0010;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("sat_gnt1_c%0d", c), 3'd1, 1'b1);
        end
        req = 8'b0001_0010;
        step();
        chk("sat_to4", 3'd4, 1'b1);

        // Unrequested bit 0 never granted on release of 4 (ptr becomes 5)
        req = 8'b0010_0000;
        step();
        chk("gnt5", 3'd5, 1'b1);

        // Asynchronous reset mid-grant, then arbitration from ptr=0
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_drop", 3'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        req = 8'b1010_0000;
        step();
        chk("post_rst_gnt5", 3'd5, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 16, max consecutive cycles one requester holds grant while another waits (legal 1..255).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  8  request vector; bit k = requester k wants the shared resource.
REQ-005 SHALL have port: gnt  output  8  registered one-hot grant; all-zero when idle.
REQ-006 SHALL have port: gnt_idx  output  3  binary index of current grant holder; 0 when idle.
REQ-007 SHALL have port: gnt_valid  output  1  high exactly when gnt is non-zero.

Function
REQ-008 SHALL implement a 2-state FSM: IDLE (no grant) and GRANT (one holder).
REQ-009 SHALL hold a 3-bit priority pointer ptr; search order is ptr, ptr+1, ..., ptr+7, modulo 8.
REQ-010 SHALL, in IDLE with req != 0, select the first set req bit in search order; gnt, gnt_idx and gnt_valid SHALL update on the next rising edge (1-cycle latency).
REQ-011 SHALL, in IDLE with req == 0, remain in IDLE with all outputs zero.
REQ-012 SHALL keep gnt one-hot and gnt == (8'b1 << gnt_idx) whenever gnt_valid = 1.
REQ-013 SHALL, in GRANT, keep the grant while req[gnt_idx] = 1 and no timeout applies.
REQ-014 SHALL treat req[gnt_idx] = 0 as release: at that edge set ptr = gnt_idx+1 (mod 8); if any other req bit is set, grant the next requester in the new search order at that same edge (back-to-back, no idle cycle); otherwise go to IDLE with outputs zero.
REQ-015 SHALL keep an 8-bit hold counter, cleared on each new grant, incremented each GRANT cycle, saturating at MAX_HOLD.
REQ-016 SHALL, when hold counter equals MAX_HOLD-1 and any other req bit is set, force rotation at the next edge exactly as in REQ-014, even if req[gnt_idx] is still 1.
REQ-017 SHALL, when timeout is reached and no other requester is pending, keep the current grant; counter saturates; rotation occurs at the first edge another request is seen.
REQ-018 SHALL wrap ptr from 7 to 0; requester 7 releasing SHALL give requester 0 highest priority.
REQ-019 SHALL ignore changes on non-holder req bits during GRANT except for rotation decisions.
REQ-020 SHALL never grant a requester whose req bit was 0 at the deciding edge.

Reset
REQ-021 SHALL, on rst_n = 0, immediately (asynchronously) force state = IDLE, gnt = 0, gnt_idx = 0, gnt_valid = 0, ptr = 0, hold counter = 0.
REQ-022 SHALL, on reset asserted mid-grant, drop the grant without waiting for a clock; after rst_n rises, first arbitration uses ptr = 0.
REQ-023 SHALL begin arbitration on the first rising clk edge after rst_n deasserts.

Verification
REQ-024 Reset then req = 8'b0000_0000 for 5 cycles -> gnt = 0, gnt_valid = 0, gnt_idx = 0 throughout.
REQ-025 After reset, req = 8'b0010_0100 -> next edge gnt = 8'b0000_0100, gnt_idx = 2; drop req[2] -> next edge gnt = 8'b0010_0000, gnt_idx = 5, no idle gap.
REQ-026 All eight req bits held high, each holder drops its bit one cycle after grant -> grant order 0,1,2,...,7,0 with ptr wrap 7->0.
REQ-027 MAX_HOLD = 4, req[3] held high permanently, req[6] asserted 1 cycle after grant to 3 -> gnt_idx = 3 for exactly 4 cycles, then gnt_idx = 6.
REQ-028 MAX_HOLD = 4, only req[1] high for 10 cycles -> gnt_idx = 1 all 10 cycles; assert req[4] -> grant moves to 4 on next edge.
REQ-029 Grant held by requester 5, rst_n pulsed low between edges -> gnt = 0 immediately; after release with req = 8'b1010_0000, first grant is gnt_idx = 5 (ptr = 0 search).
